demux_1ton_reg: RTL and testbench

//  Parametrised 1-to-NUM_CH registered demultiplexer with valid/ready handshakes.

---
 rtl/demux_1ton_reg.sv | 111 +++++++++++
 tb/tb_demux_1ton_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1ton_reg.sv
// Registered 1-to-NUM_CH demultiplexer with valid/ready flow control, broadcast mode,
// per-channel one-deep output registers and per-channel delivered-word counters.
module demux_1ton_reg #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_bcast,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    input  logic                     cnt_clr,
    output logic [NUM_CH*CNT_W-1:0]  ch_count,
    output logic                     sel_err
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // Ready never depends on valid on the same side, so there is no combinational loop
    // through the upstream source; once valid is raised the word is held until accepted.

    logic [NUM_CH-1:0] valid_q;
    logic [DATA_W-1:0] data_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic              sel_err_q;

    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] sel_hot;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] drain;
    logic              sel_in_range;
    logic              accept;

    // One-hot decode of in_sel; an all-zero result means the index is past the last channel.
    always_comb begin
        sel_hot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sel_hot[k] = (32'(in_sel) == k);
        end
        sel_in_range = |sel_hot;
    end

    always_comb begin
        free  = ~valid_q | out_ready;
        drain = valid_q & out_ready;

        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_in_range) begin
            in_ready = |(free & sel_hot);
        end else begin
            in_ready = 1'b1;
        end

        accept = in_valid && in_ready;

        if (!accept) begin
            load = '0;
        end else if (in_bcast) begin
            load = '1;
        end else begin
            load = sel_hot;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // A load only happens when the channel is free, so a stalled word is never overwritten.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q[g] <= 1'b0;
                data_q[g]  <= '0;
            end else if (load[g]) begin
                valid_q[g] <= 1'b1;
                data_q[g]  <= in_data;
            end else if (drain[g]) begin
                valid_q[g] <= 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[g] <= '0;
            end else if (cnt_clr) begin
                cnt_q[g] <= '0;
            end else if (drain[g]) begin
                cnt_q[g] <= cnt_q[g] + 1'b1;
            end
        end

        assign out_data[g*DATA_W +: DATA_W] = data_q[g];
        assign ch_count[g*CNT_W +: CNT_W]   = cnt_q[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= accept && !in_bcast && !sel_in_range;
        end
    end

    assign out_valid = valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_demux_1ton_reg.sv
// Self-checking bench for demux_1ton_reg (3 channels, 4-bit counters) using a reference
// occupancy model and per-channel expected-data queues.
module tb_demux_1ton_reg;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 3;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    logic                     clk;
    logic                     rst_n;
    logic [DATA_W-1:0]        in_data;
    logic [SEL_W-1:0]         in_sel;
    logic                     in_bcast;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic                     cnt_clr;
    logic [NUM_CH*CNT_W-1:0]  ch_count;
    logic                     sel_err;

    demux_1ton_reg #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .ch_count(ch_count), .sel_err(sel_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // scoreboard / reference model
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    logic [NUM_CH-1:0] mdl_valid;
    logic [CNT_W-1:0]  exp_cnt [NUM_CH];
    logic              exp_sel_err;
    logic              last_acc;
    logic              rand_ready;

    logic [NUM_CH-1:0] m_free;
    logic              m_ready;
    logic              m_acc;
    logic [NUM_CH-1:0] m_load;

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            exp_q[k].delete();
            exp_cnt[k] = '0;
        end
        mdl_valid   = '0;
        exp_sel_err = 1'b0;
        last_acc    = 1'b0;
    endtask

    // Inputs change at posedge+1, so the negedge sees exactly what the next edge will use.
    always @(negedge clk) begin
        if (rst_n) begin
            m_free = ~mdl_valid | out_ready;
            if (in_bcast)                 m_ready = &m_free;
            else if (int'(in_sel) < NUM_CH) m_ready = m_free[in_sel];
            else                          m_ready = 1'b1;

            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(mdl_valid));
            check("sel_err", 32'(sel_err), 32'(exp_sel_err));
            for (int k = 0; k < NUM_CH; k++)
                check($sformatf("ch%0d_count", k), 32'(ch_count[k*CNT_W +: CNT_W]), 32'(exp_cnt[k]));

            m_acc  = in_valid && m_ready;
            m_load = '0;
            exp_sel_err = 1'b0;
            if (m_acc) begin
                if (in_bcast) m_load = '1;
                else if (int'(in_sel) < NUM_CH) m_load[in_sel] = 1'b1;
                else exp_sel_err = 1'b1;
            end

            for (int k = 0; k < NUM_CH; k++) begin
                if (mdl_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0)
                        check($sformatf("ch%0d_unexpected", k), 32'(1), 32'(0));
                    else
                        check($sformatf("ch%0d_data", k), 32'(out_data[k*DATA_W +: DATA_W]),
                              32'(exp_q[k].pop_front()));
                    mdl_valid[k] = m_load[k];
                    exp_cnt[k]   = cnt_clr ? '0 : exp_cnt[k] + 1'b1;
                end else begin
                    if (m_load[k]) mdl_valid[k] = 1'b1;
                    if (cnt_clr) exp_cnt[k] = '0;
                end
                if (m_load[k]) exp_q[k].push_back(in_data);
            end
            last_acc = m_acc;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1));
        end
    end

    // driver
    task automatic send(input logic [SEL_W-1:0] sel, input logic bc, input logic [DATA_W-1:0] d);
        int waited;
        in_sel   = sel;
        in_bcast = bc;
        in_data  = d;
        in_valid = 1'b1;
        waited   = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!last_acc && waited < 60);
        if (!last_acc) check("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0;
        out_ready = '0; cnt_clr = 1'b0; rand_ready = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_ch_count", 32'(ch_count), 32'(0));
        check("rst_sel_err", 32'(sel_err), 32'(0));
        idle(2);
        rst_n = 1'b1;

        // unicast to ch2
        out_ready = '1;
        send(2'd2, 1'b0, 8'hA5);
        idle(2);
        check("t1_ch2_count", 32'(ch_count[2*CNT_W +: CNT_W]), 32'(1));

        // backpressure on ch1
        out_ready = 3'b101;
        send(2'd1, 1'b0, 8'h11);
        fork
            send(2'd1, 1'b0, 8'h22);
            begin idle(4); out_ready[1] = 1'b1; end
        join
        idle(2);
        check("t2_ch1_count", 32'(ch_count[1*CNT_W +: CNT_W]), 32'(2));

        // broadcast blocked by a stalled ch2
        out_ready = 3'b011;
        send(2'd2, 1'b0, 8'h77);
        fork
            send(2'd0, 1'b1, 8'h3C);
            begin idle(3); out_ready = '1; end
        join
        idle(2);
        check("t3_ch2_count", 32'(ch_count[2*CNT_W +: CNT_W]), 32'(3));

        // streaming to ch0, 18 words wraps a 4-bit count to 3
        for (int i = 0; i < 18; i++) send(2'd0, 1'b0, DATA_W'(i * 7 + 1));
        idle(2);
        check("t4_ch0_count", 32'(ch_count[0 +: CNT_W]), 32'(3));

        // out-of-range select
        send(2'd3, 1'b0, 8'hFF);
        idle(2);

        // random traffic with random downstream readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++)
            send(SEL_W'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                 DATA_W'($urandom_range(0, 255)));
        rand_ready = 1'b0;
        idle(1);
        out_ready = '1;
        idle(3);
        for (int k = 0; k < NUM_CH; k++)
            check($sformatf("ch%0d_q_empty", k), 32'(exp_q[k].size()), 32'(0));

        // clear during a drain
        send(2'd0, 1'b0, 8'h5A);
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        check("t6_cnt_clr", 32'(ch_count[0 +: CNT_W]), 32'(0));

        // reset with a stalled word and nonzero counts
        send(2'd1, 1'b0, 8'h42);
        out_ready = 3'b110;
        send(2'd0, 1'b0, 8'h99);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_out_data", 32'(out_data), 32'(0));
        check("mid_rst_ch_count", 32'(ch_count), 32'(0));
        check("mid_rst_sel_err", 32'(sel_err), 32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = '1;
        send(2'd0, 1'b0, 8'hC3);
        idle(3);
        check("post_rst_ch0_count", 32'(ch_count[0 +: CNT_W]), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
